// File: rtl/cms_trace_packetizer.sv
// Trace packetizer: captures each retired instr/pc with per-event counts into a wide AXI-Stream packet.
// Optional feature macro CMS_PKT_HALT_CYCLES_EN: a halted-cycle count is carried in the packet's top 32 bits.
module cms_trace_packetizer #(
    parameter int XLEN            = 64,
    parameter int NUM_EVENTS      = 39,
    parameter int CNT_WIDTH       = 7,
    parameter int AXI_DATA_WIDTH  = 1024,
    parameter int CTRL_ADDR_WIDTH = 8,
    parameter int CTRL_DATA_WIDTH = 64,
    parameter int TLAST_DEFAULT   = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       instr_valid,
    input  logic [31:0]                instr,
    input  logic [XLEN-1:0]            pc,
    input  logic [NUM_EVENTS-1:0]      performance_events,
    input  logic [CTRL_ADDR_WIDTH-1:0] ctrl_addr,
    input  logic [CTRL_DATA_WIDTH-1:0] ctrl_wdata,
    input  logic                       ctrl_write_enable,
    output logic                       M_AXIS_tvalid,
    input  logic                       M_AXIS_tready,
    output logic [AXI_DATA_WIDTH-1:0]  M_AXIS_tdata,
    output logic                       M_AXIS_tlast,
    output logic                       halt_cpu,
    output logic [63:0]                item_counter,
    output logic [31:0]                drop_counter
);
    localparam int EV_BASE = 32 + XLEN;
    localparam int EV_BITS = NUM_EVENTS * CNT_WIDTH;

    generate
        if (32 + XLEN + EV_BITS + 32 > AXI_DATA_WIDTH) begin : g_width_check
            $error("cms_trace_packetizer: packet fields do not fit in AXI_DATA_WIDTH");
        end
    endgenerate

    // Control: a write acts only on the rising edge of the strobe.
    logic        ctrl_we_prev_reg;
    logic        ctrl_fire;
    logic        wr_interval;
    logic        wr_sat;
    logic        wr_force;
    logic [31:0] tlast_interval_reg;
    logic [31:0] interval_eff;
    logic        sat_mode_reg;
    logic        sat_eff;
    logic        force_tlast_reg;
    logic        force_eff;
    logic [31:0] window_reg;
    logic [31:0] window_base;
    logic [31:0] window_inc;
    logic        pkt_last;

    assign ctrl_fire   = ctrl_write_enable && !ctrl_we_prev_reg;
    assign wr_interval = ctrl_fire && (ctrl_addr == CTRL_ADDR_WIDTH'(1));
    assign wr_sat      = ctrl_fire && (ctrl_addr == CTRL_ADDR_WIDTH'(2));
    assign wr_force    = ctrl_fire && (ctrl_addr == CTRL_ADDR_WIDTH'(3));

    // Effective settings let a write in the same cycle as a capture govern that capture.
    assign interval_eff = wr_interval ? ctrl_wdata[31:0] : tlast_interval_reg;
    assign sat_eff      = wr_sat ? ctrl_wdata[0] : sat_mode_reg;
    assign force_eff    = wr_force || force_tlast_reg;
    assign window_base  = (wr_interval || wr_force) ? 32'd0 : window_reg;
    assign window_inc   = window_base + 32'd1;
    assign pkt_last     = force_eff || ((interval_eff != 32'd0) && (window_inc == interval_eff));

    logic unused_wdata_hi;
    assign unused_wdata_hi = ^ctrl_wdata[CTRL_DATA_WIDTH-1:32];

    // FIFO occupancy and handshake
    logic [1:0] count_reg;
    logic [1:0] count_next;
    logic       capture;
    logic       pop;
    logic       accept;
    logic       wr_slot;

    assign capture    = en && instr_valid;
    assign pop        = (count_reg != 2'd0) && M_AXIS_tready;
    assign accept     = capture && ((count_reg != 2'd2) || pop);
    assign count_next = count_reg + {1'b0, accept} - {1'b0, pop};
    assign wr_slot    = (count_reg == 2'd2) || ((count_reg == 2'd1) && !pop);
    assign halt_cpu   = (count_reg == 2'd2);

    // Per-event counters; the packet field is the count including this cycle's pulse.
    logic [NUM_EVENTS-1:0][CNT_WIDTH-1:0] ev_field;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_EVENTS; gi++) begin : g_ev
            logic [CNT_WIDTH-1:0] cnt_reg;
            logic                 hit;

            assign hit = en && performance_events[gi];
            assign ev_field[gi] = !hit ? cnt_reg :
                                  (sat_eff && (&cnt_reg)) ? cnt_reg :
                                  cnt_reg + CNT_WIDTH'(1);

            // A dropped capture leaves the count accumulating.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (accept) begin
                    cnt_reg <= '0;
                end else if (hit) begin
                    cnt_reg <= ev_field[gi];
                end
            end
        end
    endgenerate

    logic [31:0] halt_field;

`ifdef CMS_PKT_HALT_CYCLES_EN
    logic [31:0] halt_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            halt_cnt_reg <= '0;
        end else if (accept) begin
            halt_cnt_reg <= '0;
        end else if (halt_cpu && (halt_cnt_reg != '1)) begin
            halt_cnt_reg <= halt_cnt_reg + 32'd1;
        end
    end

    assign halt_field = halt_cnt_reg;
`else
    assign halt_field = 32'd0;
`endif

    logic [AXI_DATA_WIDTH-1:0] pkt_next;

    always_comb begin
        pkt_next = '0;
        pkt_next[31:0] = instr;
        pkt_next[32 +: XLEN] = pc;
        pkt_next[EV_BASE +: EV_BITS] = ev_field;
        pkt_next[AXI_DATA_WIDTH-32 +: 32] = halt_field;
    end

    // Two-slot FIFO; slot 0 is the head presented on the stream.
    logic [AXI_DATA_WIDTH-1:0] fifo_data_reg [2];
    logic [1:0]                fifo_last_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg        <= 2'd0;
            fifo_data_reg[0] <= '0;
            fifo_data_reg[1] <= '0;
            fifo_last_reg    <= 2'b00;
        end else begin
            count_reg <= count_next;
            if (pop) begin
                fifo_data_reg[0] <= fifo_data_reg[1];
                fifo_last_reg[0] <= fifo_last_reg[1];
            end
            if (accept) begin
                fifo_data_reg[wr_slot] <= pkt_next;
                fifo_last_reg[wr_slot] <= pkt_last;
            end
        end
    end

    assign M_AXIS_tvalid = (count_reg != 2'd0);
    assign M_AXIS_tdata  = fifo_data_reg[0];
    assign M_AXIS_tlast  = fifo_last_reg[0];

    logic [63:0] item_count_reg;
    logic [31:0] drop_count_reg;

    // Any tlast packet, interval or forced, ends the DMA block and restarts the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_we_prev_reg   <= 1'b0;
            tlast_interval_reg <= 32'(TLAST_DEFAULT);
            sat_mode_reg       <= 1'b0;
            force_tlast_reg    <= 1'b0;
            window_reg         <= 32'd0;
            item_count_reg     <= 64'd0;
            drop_count_reg     <= 32'd0;
        end else begin
            ctrl_we_prev_reg   <= ctrl_write_enable;
            tlast_interval_reg <= interval_eff;
            sat_mode_reg       <= sat_eff;
            force_tlast_reg    <= force_eff && !accept;
            window_reg         <= accept ? (pkt_last ? 32'd0 : window_inc) : window_base;
            if (accept) begin
                item_count_reg <= item_count_reg + 64'd1;
            end
            if (capture && !accept && (drop_count_reg != '1)) begin
                drop_count_reg <= drop_count_reg + 32'd1;
            end
        end
    end

    assign item_counter = item_count_reg;
    assign drop_counter = drop_count_reg;

endmodule
